// File: rtl/aux_stat_uart_tx_pkg.sv
// Shared constants and helpers for the performance-counter UART dump.
// Contents:
//   - ASCII codes used in the dump line (space, CR, LF, '0', 'A'-10)
//   - sequencer state encoding
//   - cnt_baud(): clk cycles per UART bit for a given clock and baud rate
//   - hex_char(): nibble -> uppercase ASCII hex digit
package aux_stat_uart_tx_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A_M10 = 8'h37;  // 'A' - 10

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_HEX  = 3'd1,
        SEQ_SEP  = 3'd2,
        SEQ_CR   = 3'd3,
        SEQ_LF   = 3'd4
    } seq_state_e;

    // Rounded clk cycles per bit, e.g. cnt_baud(100_000_000, 115_200) = 868.
    function automatic int unsigned cnt_baud(input int unsigned clk_hz,
                                             input int unsigned rate);
        return (clk_hz + (rate / 32'd2)) / rate;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = ASCII_ZERO + {4'h0, nib};
        end else begin
            c = ASCII_A_M10 + {4'h0, nib};
        end
        return c;
    endfunction

endpackage

// File: rtl/aux_uart_byte_tx.sv
// UART 8N1 byte serializer with a valid/ready byte input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data       : byte to send, taken when valid && ready
//   valid      : data holds a byte to send
//   ready      : high when idle, and in the last cycle of a stop bit so the
//                next byte's start bit follows with no gap
//   tx         : serial line (registered), idle high
module aux_uart_byte_tx #(
    parameter int unsigned BaudCnt = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned BW = (BaudCnt > 1) ? $clog2(BaudCnt) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BaudCnt - 1);

    logic [9:0]    shift_q, shift_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic          active_q, active_d;
    logic          tx_q, tx_d;
    logic          last_s;

    assign last_s = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);
    assign ready  = !active_q || last_s;
    assign tx     = tx_q;

    // Next-state logic: load a frame, advance bits every BaudCnt cycles, go idle.
    always_comb begin
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (ready && valid) begin
            // shift_q[0] always mirrors the bit currently on the line
            shift_d  = {1'b1, data, 1'b0};
            baud_d   = '0;
            bit_d    = 4'd0;
            active_d = 1'b1;
            tx_d     = 1'b0;
        end else if (last_s) begin
            baud_d   = '0;
            bit_d    = 4'd0;
            active_d = 1'b0;
            tx_d     = 1'b1;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d  = '0;
                bit_d   = bit_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
                tx_d    = shift_q[1];
            end else begin
                baud_d  = baud_q + 1'b1;
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    // State registers; tx resets high so the line idles immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= 10'h3FF;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/aux_stat_uart_tx.sv
// Performance-counter dump transmitter. On an accepted start it snapshots
// WordCnt 32-bit words and sends them as one ASCII hex line over UART 8N1:
// "XXXXXXXX XXXXXXXX ... XXXXXXXX\r\n" (73 bytes for 8 words), word 0 first.
// Ports:
//   clk, rst_n : board clock, asynchronous active-low reset
//   start      : dump request, accepted only when idle and not in the done cycle
//   words      : word i = words[32*i+31 -: 32]
//   tx         : UART line, idle high
//   busy       : from the cycle after acceptance until the last stop bit ends
//   done       : one-cycle pulse in the cycle busy falls
module aux_stat_uart_tx
    import aux_stat_uart_tx_pkg::*;
#(
    parameter int unsigned BaudCnt = cnt_baud(32'd100_000_000, 32'd115_200),
    parameter int unsigned WordCnt = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [32*WordCnt-1:0]  words,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    seq_state_e            state_q, state_d;
    logic [2:0]            word_idx_q, word_idx_d;
    logic [2:0]            nib_idx_q, nib_idx_d;
    logic [32*WordCnt-1:0] snap_q, snap_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           cur_word_s;
    logic [7:0]            byte_s;
    logic                  valid_s;
    logic                  ready_s;

    assign cur_word_s = snap_q[{word_idx_q, 5'b00000} +: 32];
    assign busy       = busy_q;
    assign done       = done_q;

    // Sequencer: the state names the byte to present next, so the following
    // byte is already valid while the current one is shifting out.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        nib_idx_d  = nib_idx_q;
        snap_d     = snap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_s     = 8'h00;
        valid_s    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (busy_q) begin
                    // LF is on the line; finish when its stop bit ends
                    if (ready_s) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end else if (start && !done_q) begin
                    // First char comes straight from words: the snapshot is
                    // only written at the end of this cycle.
                    snap_d     = words;
                    byte_s     = hex_char(words[31:28]);
                    valid_s    = 1'b1;
                    busy_d     = 1'b1;
                    word_idx_d = 3'd0;
                    nib_idx_d  = 3'd6;
                    state_d    = SEQ_HEX;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_HEX: begin
                byte_s  = hex_char(cur_word_s[{nib_idx_q, 2'b00} +: 4]);
                valid_s = 1'b1;
                if (ready_s) begin
                    if (nib_idx_q != 3'd0) begin
                        nib_idx_d = nib_idx_q - 3'd1;
                    end else if (word_idx_q == 3'(WordCnt - 1)) begin
                        state_d = SEQ_CR;
                    end else begin
                        state_d = SEQ_SEP;
                    end
                end else begin
                    state_d = SEQ_HEX;
                end
            end
            SEQ_SEP: begin
                byte_s  = ASCII_SPACE;
                valid_s = 1'b1;
                if (ready_s) begin
                    word_idx_d = word_idx_q + 3'd1;
                    nib_idx_d  = 3'd7;
                    state_d    = SEQ_HEX;
                end else begin
                    state_d = SEQ_SEP;
                end
            end
            SEQ_CR: begin
                byte_s  = ASCII_CR;
                valid_s = 1'b1;
                if (ready_s) begin
                    state_d = SEQ_LF;
                end else begin
                    state_d = SEQ_CR;
                end
            end
            SEQ_LF: begin
                byte_s  = ASCII_LF;
                valid_s = 1'b1;
                if (ready_s) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_LF;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer, snapshot and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_IDLE;
            word_idx_q <= 3'd0;
            nib_idx_q  <= 3'd0;
            snap_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            nib_idx_q  <= nib_idx_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    aux_uart_byte_tx #(
        .BaudCnt (BaudCnt)
    ) u_byte_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (byte_s),
        .valid (valid_s),
        .ready (ready_s),
        .tx    (tx)
    );

endmodule

// File: tb/tb_aux_stat_uart_tx.sv
module tb_aux_stat_uart_tx;

    localparam int BAUD   = 4;
    localparam int NBYTES = 73;
    localparam int NCYC   = NBYTES * 10 * BAUD;  // 2920

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] words;
    logic         tx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    aux_stat_uart_tx #(.BaudCnt(BAUD), .WordCnt(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .words (words),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the dump line as text, built with a digit lookup table.
    function automatic string dump_text(input logic [255:0] w);
        string hexdig;
        string s;
        logic [31:0] wd;
        hexdig = "0123456789ABCDEF";
        s = "";
        for (int i = 0; i < 8; i++) begin
            wd = w[32*i +: 32];
            for (int n = 7; n >= 0; n--) begin
                s = {s, $sformatf("%c", hexdig[int'(wd[4*n +: 4])])};
            end
            s = {s, (i < 7) ? " " : "\r\n"};
        end
        return s;
    endfunction

    // Line level expected for bit j (0 start .. 9 stop) of a character.
    function automatic logic frame_bit(input logic [7:0] c, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return c[j-1];
    endfunction

    function automatic logic [255:0] rand_words();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // Called at the negedge of the first start-bit cycle; records the whole
    // dump, checks each byte cycle by cycle, then checks the done cycle.
    task automatic capture_dump(input logic [255:0] w, input bit scramble,
                                input bit poke, input string name);
        string exp_s;
        logic  cap [NCYC];
        int    busy_low;
        int    done_hi;
        int    errs;
        logic [7:0] got;
        logic [7:0] ec;
        exp_s    = dump_text(w);
        busy_low = 0;
        done_hi  = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) @(negedge clk);
            cap[c] = tx;
            if (busy !== 1'b1) busy_low++;
            if (done !== 1'b0) done_hi++;
            if (scramble && c == 0) words = '1;
            if (poke && c == 600) start = 1'b1;
            if (poke && c == 601) start = 1'b0;
        end
        for (int b = 0; b < NBYTES; b++) begin
            ec   = exp_s[b];
            errs = 0;
            for (int j = 0; j < 10; j++) begin
                for (int k = 0; k < BAUD; k++) begin
                    if (cap[b*10*BAUD + j*BAUD + k] !== frame_bit(ec, j)) errs++;
                end
                if (j >= 1 && j <= 8) got[j-1] = cap[b*10*BAUD + j*BAUD + BAUD/2];
            end
            n_checks++;
            if (errs != 0)
                $display("FAIL %s byte %0d: got 0x%02h (%0d bad cycles), expected 0x%02h",
                         name, b, got, errs, ec);
            else n_pass++;
        end
        n_checks++;
        if (busy_low != 0)
            $display("FAIL %s busy: low in %0d cycles during dump, expected 0", name, busy_low);
        else n_pass++;
        n_checks++;
        if (done_hi != 0)
            $display("FAIL %s early_done: high in %0d cycles during dump, expected 0", name, done_hi);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL %s done_cycle: done=%b busy=%b tx=%b, expected done=1 busy=0 tx=1",
                     name, done, busy, tx);
        else n_pass++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_check(input int ncyc, input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL %s idle: %0d non-idle cycles, expected 0", name, bad);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        words = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_values: tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
        else n_pass++;
        rst_n = 1'b1;
        idle_check(100, "after_reset");
    endtask

    task automatic test_known_pattern();
        logic [255:0] w;
        w[31:0] = 32'hDEAD_BEEF;
        for (int i = 1; i < 8; i++) w[32*i +: 32] = 32'(i);
        words = w;
        pulse_start();
        capture_dump(w, 1'b0, 1'b0, "known");
    endtask

    task automatic test_snapshot_isolation();
        logic [255:0] w;
        w = rand_words();
        words = w;
        pulse_start();
        capture_dump(w, 1'b1, 1'b1, "snapshot");
        idle_check(200, "no_second_dump");
    endtask

    task automatic test_back_to_back();
        logic [255:0] w1;
        logic [255:0] w2;
        w1 = rand_words();
        w2 = rand_words();
        words = w1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        capture_dump(w1, 1'b0, 1'b0, "b2b_first");
        words = w2;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b_gap: tx=%b busy=%b one cycle after done, expected 1 0", tx, busy);
        else n_pass++;
        @(negedge clk);
        capture_dump(w2, 1'b0, 1'b0, "b2b_second");
        start = 1'b0;
        idle_check(50, "b2b_end");
    endtask

    task automatic test_reset_mid_dump();
        logic [255:0] w;
        string s;
        logic [7:0] c10;
        w = rand_words();
        s = dump_text(w);
        c10 = s[10];
        words = w;
        pulse_start();
        repeat (10*10*BAUD + 4*BAUD) @(negedge clk);
        n_checks++;
        if (tx !== c10[3])
            $display("FAIL mid_dump_bit: tx=%b at byte 10 bit 4, expected %b", tx, c10[3]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check(20, "post_abort");
        w = rand_words();
        words = w;
        pulse_start();
        capture_dump(w, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_hex_corners();
        logic [255:0] w;
        w = rand_words();
        w[31:0]   = 32'h09AF_0000;
        w[63:32]  = 32'hFFFF_FFFF;
        w[95:64]  = 32'h0000_0000;
        w[127:96] = 32'h89AB_CDEF;
        words = w;
        pulse_start();
        capture_dump(w, 1'b0, 1'b0, "hex_corners");
    endtask

    initial begin
        test_reset();
        test_known_pattern();
        test_snapshot_isolation();
        test_back_to_back();
        test_reset_mid_dump();
        test_hex_corners();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
